// File: rtl/gr_scoreboard.sv
// Register-hazard scoreboard for the 32x32 GRF: per-register in-flight write counters gating ID issue.
// Optional build macro GR_SB_WB_BYPASS_EN: lets a dependent read issue in the producer's writeback cycle.
module gr_scoreboard #(
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [4:0]        id_raddr1,
    input  logic [4:0]        id_raddr2,
    input  logic [4:0]        id_raddr3,
    input  logic [2:0]        id_ruse,
    input  logic              id_we,
    input  logic [4:0]        id_waddr,
    input  logic              wb_valid,
    input  logic [4:0]        wb_waddr,
    input  logic              flush,
    output logic [31:0]       busy_vec,
    output logic [PERF_W-1:0] stall_cnt,
    output logic              err
);

    localparam int unsigned NREG = 32;
    localparam int unsigned NSRC = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NREG];
    logic [4:0]       raddr [NSRC];
    logic             src_haz;
    logic             str_haz;
    logic             issue;
    logic             err_set;
    logic [NREG-1:0]  inc;
    logic [NREG-1:0]  dec;

    assign raddr[0] = id_raddr1;
    assign raddr[1] = id_raddr2;
    assign raddr[2] = id_raddr3;

    // Issue gating: any pending source, or a saturated destination counter, holds ID.
    always_comb begin
        src_haz = 1'b0;
        for (int k = 0; k < int'(NSRC); k++) begin
            if (id_ruse[k] && raddr[k] != 5'd0 && cnt[raddr[k]] != '0) begin
`ifdef GR_SB_WB_BYPASS_EN
                // Last outstanding write is retiring now; regfile write-through supplies the data.
                if (!(wb_valid && wb_waddr == raddr[k] && cnt[raddr[k]] == CNT_W'(1))) begin
                    src_haz = 1'b1;
                end
`else
                src_haz = 1'b1;
`endif
            end
        end
        str_haz  = id_we && id_waddr != 5'd0 && cnt[id_waddr] == CNT_MAX;
        id_ready = !flush && !src_haz && !str_haz;
        issue    = id_valid && id_ready;
        err_set  = wb_valid && wb_waddr != 5'd0 && cnt[wb_waddr] == '0
                   && !(issue && id_we && id_waddr == wb_waddr);
    end

    always_comb begin
        inc      = '0;
        dec      = '0;
        busy_vec = '0;
        for (int i = 1; i < int'(NREG); i++) begin
            inc[i]      = issue && id_we && id_waddr == 5'(i);
            dec[i]      = wb_valid && wb_waddr == 5'(i) && cnt[i] != '0;
            busy_vec[i] = cnt[i] != '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                cnt[i] <= '0;
            end
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (flush || i == 0) begin
                    cnt[i] <= '0;
                end else if (inc[i] && !dec[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (dec[i] && !inc[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
            if (id_valid && !id_ready) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/gr_scoreboard.md
Name: gr_scoreboard

Overview:
- Register-hazard scoreboard for the 32x32 general register file (3 read ports, 1 write port, r0 hardwired to 0).
- Sits beside the ID stage. Counts in-flight writes per architectural register. Holds issue (id_ready=0) while any used source operand is still pending, or while the destination's counter is saturated.
- Decremented by the WB stage's register-file write. Cleared by a pipeline flush.

Parameters:
- CNT_W, 2, width of the per-register pending-write counter. Max in-flight writes per register = 2^CNT_W-1.
- PERF_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds an instruction requesting issue
- id_ready  out  1  issue permitted this cycle (combinational)
- id_raddr1  in  5  source register 1
- id_raddr2  in  5  source register 2
- id_raddr3  in  5  source register 3
- id_ruse  in  3  bit k=1: source k+1 is actually read
- id_we  in  1  issuing instruction writes a register
- id_waddr  in  5  destination register
- wb_valid  in  1  WB writes the register file this cycle (same strobe as regfile we)
- wb_waddr  in  5  WB destination register
- flush  in  1  kill all in-flight instructions younger than WB
- busy_vec  out  32  bit i=1: cnt[i]!=0 (registered state; bit 0 always 0)
- stall_cnt  out  PERF_W  cycles with id_valid=1 and id_ready=0
- err  out  1  sticky: WB write to a register whose counter is 0

Behaviour:
- Reset: rst_n is synchronous, active-low, sampled on the rising edge of clk. All cnt[i]=0, busy_vec=0, stall_cnt=0, err=0.
- State: cnt[1..31], each CNT_W bits. No storage for r0.
- Source hazard for source k: id_ruse[k] && raddr!=0 && cnt[raddr]!=0. Bypass exception is described under Optional Feature.
- Structural hazard: id_we && id_waddr!=0 && cnt[id_waddr]==2^CNT_W-1.
- id_ready = !flush && no source hazard && no structural hazard.
- id_ready is evaluated even when id_valid=0; state only changes when the instruction issues.
- issue = id_valid && id_ready.
- inc[i] = issue && id_we && id_waddr==i && i!=0.
- dec[i] = wb_valid && wb_waddr==i && i!=0 && cnt[i]!=0.
- Per register, next cnt: inc only -> +1; dec only -> -1; both -> unchanged; neither -> hold.
- wb_valid with wb_waddr!=0 and cnt[wb_waddr]==0 (and no same-cycle inc on that register): cnt stays 0 and err is set to 1. err stays set until reset.
- wb_valid with wb_waddr==0: ignored, no error.
- flush=1: every cnt becomes 0 next cycle; the same-cycle WB decrement and issue are discarded. Flush is asserted only when no valid instruction is older than WB, so the WB instruction of that same cycle is its last write.
- stall_cnt increments by 1 when id_valid && !id_ready, including cycles with flush=1. It wraps at 2^PERF_W.
- Latency: a newly issued write makes the register busy on the next cycle. A WB decrement frees the register on the next cycle, unless the bypass feature is enabled.
- Issue and WB to the same register in the same cycle is legal. Example: cnt 1 -> 1 (the old write retires, the new one is counted).
- No FSM beyond the counters. The block is fully pipelined: one issue and one retire per cycle.

Optional Feature:
- Macro: GR_SB_WB_BYPASS_EN.
- Defined: a source hazard is suppressed when wb_valid && wb_waddr==raddr && cnt[raddr]==1. The register file then provides write-through (rdata = wdata when raddr==waddr && we), so a dependent instruction issues in the same cycle as the producer's writeback.
- Undefined: no suppression. The dependent instruction issues one cycle after writeback, when the register file already holds the value.
- cnt, err and flush behaviour are identical in both builds.

Test Plan:
- Reset, then issue id_we=1 id_waddr=5 -> next cycle busy_vec[5]=1. A following instruction with id_raddr1=5 id_ruse=3'b001 sees id_ready=0 and stall_cnt increments each cycle. Then wb_valid=1 wb_waddr=5 -> without the bypass macro, id_ready=1 the next cycle. With GR_SB_WB_BYPASS_EN, id_ready=1 in the WB cycle itself.
- With CNT_W=2, issue three writes to r7 -> cnt[7]=3. A fourth instruction writing r7 sees id_ready=0 (structural hazard). After one WB to r7, id_ready=1.
- Issue with id_waddr=0 id_we=1, then read r0 with id_ruse=3'b111 -> busy_vec=0 and id_ready stays 1.
- cnt[9]=1, then in the same cycle issue a write to r9 and WB r9 -> cnt[9] stays 1 and busy_vec[9]=1.
- busy_vec=32'h0000_0F00, assert flush for one cycle -> id_ready=0 during flush, busy_vec=0 next cycle, no err.
- WB to r3 while cnt[3]=0 -> err=1, stays 1 afterwards. Assert rst_n=0 for one clock -> err=0, stall_cnt=0.
